// File: rtl/operand_entry.sv
// Purpose: collects decimal keypad digits and a sign, then converts them to a two's-complement value.
// Latency: DIGITS+1 cycles from the enter strobe to out_valid; one digit is folded in per CONV cycle.
// Backpressure: the result is held in HOLD until out_ready; keys are ignored in CONV and in HOLD (except clear).
//
// Ports:
//   clk, rst           - single clock, synchronous active-high reset
//   key_stb, key_code  - one-cycle key strobe; 0-9 digit, 10 sign, 11 backspace, 12 clear, 13 enter
//   bcd, neg, ndig     - current entry: digits (LSD in [3:0]), sign, digit count
//   busy               - high while converting or holding a result
//   value, err         - converted result and out-of-range flag, qualified by out_valid
//   out_valid/out_ready- result handshake
// Build option: define OPERAND_ENTRY_SATURATE_EN to saturate out-of-range results instead of zeroing them.
module operand_entry #(
  parameter int DIGITS = 3,
  parameter int WIDTH  = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                key_stb,
  input  logic [3:0]          key_code,
  output logic [4*DIGITS-1:0] bcd,
  output logic                neg,
  output logic [2:0]          ndig,
  output logic                busy,
  output logic [WIDTH-1:0]    value,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                err
);

  localparam int BW = 4 * DIGITS;
  localparam int AW = $clog2(10 ** DIGITS);
  localparam logic [31:0] POS_MAX = (32'd1 << (WIDTH - 1)) - 32'd1;
  localparam logic [31:0] NEG_MAX = 32'd1 << (WIDTH - 1);

  localparam logic [3:0] K_SIGN  = 4'd10;
  localparam logic [3:0] K_BKSP  = 4'd11;
  localparam logic [3:0] K_CLEAR = 4'd12;
  localparam logic [3:0] K_ENTER = 4'd13;

  typedef enum logic [1:0] {S_EMPTY, S_ENTRY, S_CONV, S_HOLD} state_t;

  state_t           state_q, state_d;
  logic [BW-1:0]    bcd_q, bcd_d;
  logic             neg_q, neg_d;
  logic [2:0]       ndig_q, ndig_d;
  logic [BW-1:0]    conv_q, conv_d;   // working copy of bcd, shifted left so the next digit is on top
  logic [AW-1:0]    mag_q, mag_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic             err_q, err_d;

  logic [AW-1:0]    mag_nx;
  logic [31:0]      mag_ext;
  logic             in_range;

  always_comb begin
    state_d  = state_q;
    bcd_d    = bcd_q;
    neg_d    = neg_q;
    ndig_d   = ndig_q;
    conv_d   = conv_q;
    mag_d    = mag_q;
    cnt_d    = cnt_q;
    value_d  = value_q;
    err_d    = err_q;

    // Intermediate values never exceed 10^DIGITS-1, so AW bits suffice throughout.
    mag_nx   = (mag_q * AW'(10)) + AW'(conv_q[BW-1 -: 4]);
    mag_ext  = 32'(mag_nx);
    in_range = neg_q ? (mag_ext <= NEG_MAX) : (mag_ext <= POS_MAX);

    case (state_q)
      S_EMPTY, S_ENTRY: begin
        if (key_stb) begin
          if (key_code <= 4'd9) begin
            if (ndig_q < 3'(DIGITS)) begin
              bcd_d   = (bcd_q << 4) | BW'(key_code);
              ndig_d  = ndig_q + 3'd1;
              state_d = S_ENTRY;
            end
          end else if (key_code == K_SIGN) begin
            neg_d = ~neg_q;
          end else if (key_code == K_BKSP) begin
            // EMPTY already has no digits, so backspace only acts in ENTRY.
            if (state_q == S_ENTRY) begin
              bcd_d  = bcd_q >> 4;
              ndig_d = ndig_q - 3'd1;
              if (ndig_q == 3'd1) state_d = S_EMPTY;
            end
          end else if (key_code == K_CLEAR) begin
            bcd_d   = '0;
            ndig_d  = '0;
            neg_d   = 1'b0;
            state_d = S_EMPTY;
          end else if (key_code == K_ENTER) begin
            // bcd is all zero in EMPTY, so the same conversion yields 0; only the sign needs forcing.
            if (state_q == S_EMPTY) neg_d = 1'b0;
            conv_d  = bcd_q;
            mag_d   = '0;
            cnt_d   = '0;
            state_d = S_CONV;
          end
        end
      end

      S_CONV: begin
        conv_d = conv_q << 4;
        mag_d  = mag_nx;
        cnt_d  = cnt_q + 3'd1;
        if (cnt_q == 3'(DIGITS - 1)) begin
          state_d = S_HOLD;
          if (in_range) begin
            value_d = neg_q ? WIDTH'(32'd0 - mag_ext) : WIDTH'(mag_ext);
            err_d   = 1'b0;
          end else begin
`ifdef OPERAND_ENTRY_SATURATE_EN
            value_d = neg_q ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`else
            value_d = '0;
`endif
            err_d   = 1'b1;
          end
        end
      end

      S_HOLD: begin
        // Handshake or clear both return to EMPTY; any other key this cycle is dropped.
        if (out_ready || (key_stb && (key_code == K_CLEAR))) begin
          bcd_d   = '0;
          ndig_d  = '0;
          neg_d   = 1'b0;
          state_d = S_EMPTY;
        end
      end

      default: state_d = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_EMPTY;
      bcd_q   <= '0;
      neg_q   <= 1'b0;
      ndig_q  <= '0;
      conv_q  <= '0;
      mag_q   <= '0;
      cnt_q   <= '0;
      value_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bcd_q   <= bcd_d;
      neg_q   <= neg_d;
      ndig_q  <= ndig_d;
      conv_q  <= conv_d;
      mag_q   <= mag_d;
      cnt_q   <= cnt_d;
      value_q <= value_d;
      err_q   <= err_d;
    end
  end

  assign bcd       = bcd_q;
  assign neg       = neg_q;
  assign ndig      = ndig_q;
  assign value     = value_q;
  assign err       = err_q;
  assign busy      = (state_q == S_CONV) || (state_q == S_HOLD);
  assign out_valid = (state_q == S_HOLD);

endmodule

// File: tb/tb_operand_entry.sv
// Bench for operand_entry with DIGITS=3, WIDTH=8.
// Conversion vectors are table driven; entry editing, backpressure, reset and
// handshake corner cases are hand-written sequences.
module tb_operand_entry;
  localparam int DIGITS = 3;
  localparam int WIDTH  = 8;

`ifdef OPERAND_ENTRY_SATURATE_EN
  localparam logic [7:0] OVP = 8'h7F;
  localparam logic [7:0] OVN = 8'h80;
`else
  localparam logic [7:0] OVP = 8'h00;
  localparam logic [7:0] OVN = 8'h00;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        key_stb;
  logic [3:0]  key_code;
  logic [11:0] bcd;
  logic        neg;
  logic [2:0]  ndig;
  logic        busy;
  logic [7:0]  value;
  logic        out_valid;
  logic        out_ready;
  logic        err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  operand_entry #(.DIGITS(DIGITS), .WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .key_stb  (key_stb),
    .key_code (key_code),
    .bcd      (bcd),
    .neg      (neg),
    .ndig     (ndig),
    .busy     (busy),
    .value    (value),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .err      (err)
  );

  // Keys are packed left-justified: first key in [19:16].
  typedef struct {
    int          nk;
    logic [19:0] keys;
    logic [7:0]  val;
    logic        er;
  } vec_t;

  vec_t vt[15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic press(input logic [3:0] k);
    @(negedge clk);
    key_stb  = 1'b1;
    key_code = k;
    @(negedge clk);
    key_stb  = 1'b0;
    key_code = 4'd0;
  endtask

  // Returns at a falling edge; n is the number of falling edges waited (20 on timeout).
  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic ack();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    int n;
    logic [3:0] k;
    logic [7:0] v;

    vt[0]  = '{3, 20'h12700, 8'h7F, 1'b0};   // 127
    vt[1]  = '{4, 20'h128A0, 8'h80, 1'b0};   // -128
    vt[2]  = '{3, 20'h12800, OVP,   1'b1};   // 128 out of range
    vt[3]  = '{1, 20'h00000, 8'h00, 1'b0};   // 0
    vt[4]  = '{1, 20'h50000, 8'h05, 1'b0};   // 5
    vt[5]  = '{2, 20'h3A000, 8'hFD, 1'b0};   // -3
    vt[6]  = '{3, 20'h99900, OVP,   1'b1};   // 999
    vt[7]  = '{4, 20'h999A0, OVN,   1'b1};   // -999
    vt[8]  = '{2, 20'hA0000, 8'h00, 1'b0};   // negative zero
    vt[9]  = '{3, 20'h10000, 8'h64, 1'b0};   // 100
    vt[10] = '{4, 20'h129A0, OVN,   1'b1};   // -129
    vt[11] = '{3, 20'h64A00, 8'hC0, 1'b0};   // -64
    vt[12] = '{3, 20'h7B200, 8'h02, 1'b0};   // 7, backspace, 2
    vt[13] = '{1, 20'hA0000, 8'h00, 1'b0};   // sign then enter from EMPTY
    vt[14] = '{4, 20'h00420, 8'h04, 1'b0};   // 0,0,4 then fourth digit ignored

    rst = 1'b1; key_stb = 1'b0; key_code = 4'd0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_bcd", 32'(bcd), 32'h0);
    chk("rst_ndig", 32'(ndig), 32'h0);
    chk("rst_flags", {27'd0, neg, busy, out_valid, err, 1'b0}, 32'h0);
    chk("rst_value", 32'(value), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Table-driven conversions
    for (int i = 0; i < 15; i++) begin
      for (int j = 0; j < vt[i].nk; j++) begin
        v = vt[i].keys[19-4*j -: 4];
        k = v[3:0];
        press(k);
      end
      press(4'd13);
      wait_valid(n);
      chk($sformatf("v%0d_latency", i), 32'(n), 32'(DIGITS));
      chk($sformatf("v%0d_value", i), 32'(value), 32'(vt[i].val));
      chk($sformatf("v%0d_err", i), 32'(err), 32'(vt[i].er));
      if (i == 13) chk("v13_neg_forced", 32'(neg), 32'h0);
      ack();
      chk($sformatf("v%0d_drop_valid", i), {30'd0, out_valid, busy}, 32'h0);
      chk($sformatf("v%0d_ndig_clr", i), 32'(ndig), 32'h0);
      chk($sformatf("v%0d_value_kept", i), 32'(value), 32'(vt[i].val));
    end

    // Hold with out_ready low: result stays stable
    press(4'd1); press(4'd2); press(4'd7); press(4'd13);
    wait_valid(n);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("hold_stable", {22'd0, out_valid, busy, err, value}, {22'd0, 1'b1, 1'b1, 1'b0, 8'h7F});
    end
    ack();

    // Digit-limit, backspace and clear editing
    press(4'd4); press(4'd5); press(4'd6); press(4'd7);
    chk("limit_bcd", 32'(bcd), 32'h456);
    chk("limit_ndig", 32'(ndig), 32'd3);
    press(4'd11); press(4'd11); press(4'd9);
    chk("bksp_bcd", 32'(bcd), 32'h049);
    chk("bksp_ndig", 32'(ndig), 32'd2);
    press(4'd12);
    chk("clear_entry", {17'd0, bcd, ndig}, 32'h0);

    // Backspace to empty keeps the sign; backspace in EMPTY does nothing
    press(4'd5); press(4'd10); press(4'd11);
    chk("bksp_empty_neg", {19'd0, neg, bcd}, {19'd0, 1'b1, 12'h000});
    press(4'd11);
    chk("bksp_in_empty", {16'd0, neg, ndig, bcd}, {16'd0, 1'b1, 3'd0, 12'h000});
    press(4'd12);
    chk("clear_neg", 32'(neg), 32'h0);

    // Keys during CONV are ignored
    press(4'd2); press(4'd13); press(4'd3);
    wait_valid(n);
    chk("conv_ignore_bcd", 32'(bcd), 32'h002);
    chk("conv_ignore_val", 32'(value), 32'h02);
    // Digit in HOLD ignored, clear in HOLD drops out_valid
    press(4'd8);
    chk("hold_digit_ign", {29'd0, out_valid, ndig[1:0]}, {29'd0, 1'b1, 2'd1});
    press(4'd12);
    chk("hold_clear", {19'd0, out_valid, bcd}, 32'h0);

    // Key coincident with handshake is dropped
    press(4'd5); press(4'd13);
    wait_valid(n);
    out_ready = 1'b1; key_stb = 1'b1; key_code = 4'd7;
    @(negedge clk);
    out_ready = 1'b0; key_stb = 1'b0; key_code = 4'd0;
    chk("hs_key_drop", {16'd0, out_valid, ndig, bcd}, 32'h0);
    @(negedge clk);
    chk("hs_key_ndig", 32'(ndig), 32'h0);
    chk("hs_value_kept", 32'(value), 32'h05);

    // Reset in the second CONV cycle
    press(4'd9); press(4'd13);
    chk("conv_busy", 32'(busy), 32'h1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midconv_rst", {10'd0, bcd, neg, ndig, busy, out_valid, err, value[2:0]}, 32'h0);
    chk("midconv_value", 32'(value), 32'h0);
    repeat (4) @(negedge clk);
    chk("midconv_no_hold", {30'd0, out_valid, busy}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/operand_entry.md
OPERAND_ENTRY -- requirements
Module: operand_entry

Interface
REQ-001 SHALL have parameter DIGITS, default 3, the maximum number of decimal digits held (1..6).
REQ-002 SHALL have parameter WIDTH, default 8, the two's-complement result width (4..24).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, the synchronous active-high reset.
REQ-005 SHALL have port key_stb, input, 1, a one-cycle strobe qualifying key_code.
REQ-006 SHALL have port key_code, input, 4, with 0-9 = digit, 10 = sign toggle, 11 = backspace, 12 = clear, 13 = enter, and 14-15 ignored.
REQ-007 SHALL have port bcd, output, 4*DIGITS, the entered digits with the least significant digit in [3:0] and unused digits 0.
REQ-008 SHALL have port neg, output, 1, the current entry sign.
REQ-009 SHALL have port ndig, output, 3, the count of digits entered.
REQ-010 SHALL have port busy, output, 1, high in CONV and HOLD.
REQ-011 SHALL have port value, output, WIDTH, the two's-complement result.
REQ-012 SHALL have port out_valid, output, 1, meaning value is presented.
REQ-013 SHALL have port out_ready, input, 1, the consumer acceptance.
REQ-014 SHALL have port err, output, 1, meaning the result is out of range; it is valid with out_valid.

Function
REQ-015 SHALL implement states EMPTY, ENTRY, CONV and HOLD.
REQ-016 In EMPTY or ENTRY with ndig<DIGITS, a digit key SHALL shift bcd left by one digit, insert the key, increment ndig and go to ENTRY.
REQ-017 A digit key with ndig==DIGITS SHALL be ignored with no change.
REQ-018 A leading 0 in EMPTY SHALL be accepted and counted as a digit.
REQ-019 Sign toggle SHALL invert neg in EMPTY or ENTRY.
REQ-020 Backspace SHALL shift bcd right by one digit and decrement ndig; at ndig 1->0 the block SHALL go to EMPTY with neg retained; in EMPTY, backspace SHALL do nothing.
REQ-021 Clear SHALL zero bcd, ndig and neg and go to EMPTY from EMPTY, ENTRY or HOLD; in HOLD it SHALL also drop out_valid.
REQ-022 Enter SHALL go to CONV from ENTRY; in EMPTY it SHALL convert value 0 with neg forced to 0.
REQ-023 CONV SHALL compute mag = mag*10 + digit from the most significant digit down, one digit per cycle, over exactly DIGITS cycles, with the internal accumulator ceil(log2(10^DIGITS)) bits wide.
REQ-024 Latency SHALL be DIGITS+1 cycles from the enter strobe cycle to out_valid high.
REQ-025 Range SHALL be: positive mag <= 2^(WIDTH-1)-1; negative mag <= 2^(WIDTH-1).
REQ-026 In range, value SHALL be mag if positive, else -mag, with err=0; negative zero SHALL give value 0.
REQ-027 HOLD SHALL keep value, err and out_valid stable until out_ready is sampled high.
REQ-028 On handshake, the block SHALL go to EMPTY next cycle, with out_valid low, bcd/ndig/neg cleared and value retained.
REQ-029 key_stb SHALL be ignored in CONV, and in HOLD except clear; a key coincident with the handshake cycle SHALL be dropped.
REQ-030 out_valid SHALL be high only in HOLD.

Reset
REQ-031 rst SHALL dominate all inputs, including mid-CONV and in HOLD.
REQ-032 On reset, state SHALL be EMPTY and bcd, neg, ndig, busy, value, out_valid and err SHALL all be 0.

Configuration
REQ-033 With OPERAND_ENTRY_SATURATE_EN defined, an out-of-range result SHALL saturate value to 2^(WIDTH-1)-1 or -2^(WIDTH-1) and set err=1.
REQ-034 Without OPERAND_ENTRY_SATURATE_EN, an out-of-range result SHALL set value=0 and err=1.

Verification (DIGITS=3, WIDTH=8)
REQ-035 Keys 1,2,7, enter -> out_valid high after 4 cycles with value=0x7F and err=0; hold out_ready=0 for 5 cycles -> value stable.
REQ-036 Keys 1,2,8, toggle, enter -> value=0x80, err=0; keys 1,2,8, enter -> err=1, value=0x00, or 0x7F with the macro.
REQ-037 Keys 4,5,6,7 -> bcd=0x456 and ndig=3; then backspace, backspace, 9 -> bcd=0x049.
REQ-038 Toggle then enter from EMPTY -> value=0, neg=0, err=0.
REQ-039 Keys 9, enter, assert rst on the 2nd CONV cycle -> all outputs 0 and state EMPTY next cycle.
REQ-040 Digit key pulsed in the out_ready cycle -> ignored, and ndig=0 after return to EMPTY.
